// File: rtl/lc2k_regfile_sb.sv
// LC2K register file with per-register pending (scoreboard) bits.
// Two combinational read ports, one write port with write-through bypass.
module lc2k_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                hazard_a,
  output logic                hazard_b,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic [NUM_REGS-1:0] pend_vec,
  output logic [ADDR_W:0]     pend_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_v, is_v, byp_en;

  // An address is usable if in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign we_v   = wr_en && addr_ok(wr_addr);
  assign is_v   = issue_en && addr_ok(issue_dest);
  // Bypass is suppressed during reset so reads show the cleared state.
  assign byp_en = wr_en && !reset;

  // Next pending bits: writeback clears, issue sets; issue wins on collision.
  always_comb begin
    pend_d = pend_q;
    if (we_v) pend_d[wr_addr] = 1'b0;
    if (is_v) pend_d[issue_dest] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
  end

  // Scoreboard state and its population count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register array write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (we_v) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read port A with write-through bypass.
  always_comb begin
    rd_data_a = '0;
    hazard_a  = 1'b0;
    if (addr_ok(rd_addr_a)) begin
      if (byp_en && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = regs_q[rd_addr_a];
        hazard_a  = pend_q[rd_addr_a];
      end
    end
  end

  // Read port B with write-through bypass.
  always_comb begin
    rd_data_b = '0;
    hazard_b  = 1'b0;
    if (addr_ok(rd_addr_b)) begin
      if (byp_en && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = regs_q[rd_addr_b];
        hazard_b  = pend_q[rd_addr_b];
      end
    end
  end

  assign pend_vec = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: doc/lc2k_regfile_sb.md
Name: lc2k_regfile_sb

Overview:
Parametrised LC2K register file with a per-register pending (scoreboard) bit, for the pipelined core.
- Two combinational read ports, one clocked write port with same-cycle write-through bypass.
- Tracks which destination registers have an in-flight producer and flags read hazards to the decode stage.
- Sits between decode (reads, issue) and writeback (write, clear).

Parameters:
DATA_W, 32, register data width in bits
NUM_REGS, 8, number of architectural registers (2..2^ADDR_W)
ADDR_W, 3, register address width
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/issues; 0 = register 0 is ordinary

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  DATA_W  read port A data (combinational)
rd_data_b  output  DATA_W  read port B data (combinational)
hazard_a  output  1  port A source has an unresolved producer
hazard_b  output  1  port B source has an unresolved producer
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback value
issue_en  input  1  an instruction with a destination issues this cycle
issue_dest  input  ADDR_W  destination register of the issuing instruction
pend_vec  output  NUM_REGS  current pending bits, bit i = register i
pend_cnt  output  ADDR_W+1  number of set pending bits

Behaviour:
- Reset (async, takes effect immediately and holds while high):
  - All registers = 0; all pending bits = 0.
  - Hence rd_data_* = 0, hazard_* = 0, pend_vec = 0, pend_cnt = 0.
  - Reset asserted mid-operation discards any write/issue in that cycle.
- Valid address: addr < NUM_REGS, and not register 0 when ZERO_REG=1.
- Write:
  - On rising edge with wr_en=1 and wr_addr valid: reg[wr_addr] <= wr_data; pending[wr_addr] cleared.
  - Invalid wr_addr: write ignored, no state change.
  - Writing a register whose pending bit is clear is legal: updates data only.
- Issue:
  - On rising edge with issue_en=1 and issue_dest valid: pending[issue_dest] <= 1.
  - Invalid issue_dest: ignored.
  - Issue to an already-pending register: bit stays 1 (WAW tolerated; last writeback clears it).
- Simultaneous write and issue to the same register in one cycle: data is written; pending ends 1 (issue wins, new producer).
  - Different registers: both take effect.
- Read, per port X in {a, b}, combinational, zero latency:
  - rd_addr_X out of range, or register 0 with ZERO_REG=1: data 0, hazard 0.
  - Else, wr_en=1 and wr_addr==rd_addr_X: data = wr_data (bypass); hazard 0 that cycle.
  - Else: data = reg[rd_addr_X]; hazard = pending[rd_addr_X].
  - Both ports may address the same register; both return identical values.
- Issue does not affect reads in the same cycle: pending is visible from the next cycle.
- pend_cnt:
  - Registered, updated together with pending bits; equals popcount(pend_vec) every cycle.
  - Max value NUM_REGS (or NUM_REGS-1 when ZERO_REG=1).
- Outputs have no X after reset; no latches; no initial blocks relied upon.

Test Plan:
- Reset then read all addresses 0..7 on both ports -> rd_data=0, hazard=0, pend_vec=0, pend_cnt=0.
- Write r3=0x0000_00AA, r7=0xFFFF_FFFF; read a=3, b=7 next cycle -> 0xAA and 0xFFFFFFFF. Write r0=0x55 with ZERO_REG=1 -> r0 reads 0.
- Bypass: wr_en=1, wr_addr=5, wr_data=0x1234 while rd_addr_a=5 in the same cycle -> rd_data_a=0x1234 combinationally, hazard_a=0.
- Scoreboard:
  - issue r2 at cycle N -> hazard on r2 from N+1, pend_vec=0x04, pend_cnt=1.
  - Writeback r2=9 at cycle M -> hazard_a=0 and data 9 in cycle M (bypass); pend_vec=0 from M+1.
- Collision: r4 pending; same cycle wr r4=0x77 and issue r4 -> next cycle data 0x77, hazard still 1, pend_cnt unchanged.
- Async reset asserted mid-cycle with r1..r6 pending and data nonzero -> outputs clear before the next clk edge; a write/issue presented during reset is lost.
